// File: rtl/loteria_input_cond_if.sv
// Board-side signal bundle of the lottery input conditioner: raw switches and
// keys in, conditioned digit, pulses and status out.
interface loteria_input_cond_if;
  logic [3:0] sw_num;
  logic       key_insert_n;
  logic       key_finish_n;
  logic [3:0] num;
  logic       insert;
  logic       finish;
  logic       err;
  logic       err_led;
  logic [2:0] insert_cnt;

  // master drives the raw board inputs and observes the conditioned outputs
  modport master (
    output sw_num, key_insert_n, key_finish_n,
    input  num, insert, finish, err, err_led, insert_cnt
  );

  modport slave (
    input  sw_num, key_insert_n, key_finish_n,
    output num, insert, finish, err, err_led, insert_cnt
  );
endinterface

// File: rtl/loteria_input_cond.sv
// Input conditioner for the lottery-ticket FSM: synchronises the switches and
// keys, debounces and edge-detects the keys, validates the BCD digit.
module loteria_input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  loteria_input_cond_if.slave  bus
);

  localparam int unsigned      KEY_INS  = 0;
  localparam int unsigned      KEY_FIN  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [1:0]       key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [1:0]       sync_ok_q, sync_ok_d;
  logic [1:0]       deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [1:0]       armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       press;

  logic [3:0]       num_q, num_d;
  logic             insert_q, insert_d;
  logic             finish_q, finish_d;
  logic             err_q, err_d;
  logic             err_led_q, err_led_d;
  logic             finish_pend_q, finish_pend_d;
  logic [2:0]       insert_cnt_q, insert_cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sw_s1_d       = bus.sw_num;
    sw_s2_d       = sw_s1_q;
    key_s1_d      = {bus.key_finish_n, bus.key_insert_n};
    key_s2_d      = key_s1_q;
    sync_ok_d     = {sync_ok_q[0], 1'b1};
    deb_prev_d    = deb_q;
    deb_d         = deb_q;
    armed_d       = armed_q;
    press         = '0;

    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (key_s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = key_s2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      // A key held through reset must be seen released before it can fire;
      // sync_ok masks the synchroniser's reset-value "released" samples.
      if (sync_ok_q[1] && key_s2_q[i]) armed_d[i] = 1'b1;
      press[i] = armed_q[i] & deb_prev_q[i] & ~deb_q[i];
    end

    num_d         = num_q;
    insert_d      = 1'b0;
    err_d         = 1'b0;
    err_led_d     = err_led_q;
    insert_cnt_d  = insert_cnt_q;
    finish_d      = finish_pend_q;
    finish_pend_d = 1'b0;

    if (press[KEY_INS]) begin
      if (sw_s2_q <= 4'd9) begin
        num_d     = sw_s2_q;
        insert_d  = 1'b1;
        err_led_d = 1'b0;
        if (insert_cnt_q != 3'd7) insert_cnt_d = insert_cnt_q + 3'd1;
      end else begin
        err_d     = 1'b1;
        err_led_d = 1'b1;
      end
    end

    // Insert/err wins the cycle; a coincident finish is deferred by one.
    if (press[KEY_FIN]) begin
      if (press[KEY_INS]) finish_pend_d = 1'b1;
      else                finish_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1_q       <= '0;
      sw_s2_q       <= '0;
      key_s1_q      <= '1;
      key_s2_q      <= '1;
      sync_ok_q     <= '0;
      deb_q         <= '1;
      deb_prev_q    <= '1;
      armed_q       <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      num_q         <= '0;
      insert_q      <= 1'b0;
      finish_q      <= 1'b0;
      err_q         <= 1'b0;
      err_led_q     <= 1'b0;
      finish_pend_q <= 1'b0;
      insert_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sw_s1_q       <= sw_s1_d;
      sw_s2_q       <= sw_s2_d;
      key_s1_q      <= key_s1_d;
      key_s2_q      <= key_s2_d;
      sync_ok_q     <= sync_ok_d;
      deb_q         <= deb_d;
      deb_prev_q    <= deb_prev_d;
      armed_q       <= armed_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      num_q         <= num_d;
      insert_q      <= insert_d;
      finish_q      <= finish_d;
      err_q         <= err_d;
      err_led_q     <= err_led_d;
      finish_pend_q <= finish_pend_d;
      insert_cnt_q  <= insert_cnt_d;
    end
  end

  assign bus.num        = num_q;
  assign bus.insert     = insert_q;
  assign bus.finish     = finish_q;
  assign bus.err        = err_q;
  assign bus.err_led    = err_led_q;
  assign bus.insert_cnt = insert_cnt_q;

endmodule

// File: tb/tb_loteria_input_cond.sv
// Randomised and directed bench for loteria_input_cond; a window-based
// debounce model predicts each output pulse and a monitor checks it.
module tb_loteria_input_cond;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam int HL = D + 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  loteria_input_cond_if bus();

  loteria_input_cond #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit ins;
    bit err;
    bit fin;
    int num;
    int cnt;
    bit led;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   last_edge = -1;
  bit   rst_seen  = 1'b1;

  // reference model state
  bit   hist [2][HL];
  int   shist [2];
  bit   mdeb  [2];
  bit   armed [2];
  bit   press [2];
  int   n_real;
  int   m_num, m_cnt;
  bit   m_led;
  int   vis_num, vis_cnt;
  bit   vis_led;
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, last_edge);
    end
  endtask

  task automatic push_evt(input int cyc, input bit ins, input bit err, input bit fin);
    exp_t e;
    if (exp_q.size() > 0 && exp_q[$].cyc == cyc) begin
      e = exp_q.pop_back();
    end else begin
      e.cyc = cyc; e.ins = 0; e.err = 0; e.fin = 0;
    end
    e.ins |= ins;
    e.err |= err;
    e.fin |= fin;
    e.num = m_num;
    e.cnt = m_cnt;
    e.led = m_led;
    exp_q.push_back(e);
  endtask

  // Model: synced level = raw level two edges earlier; a key's accepted level
  // flips once the last D synced samples all differ from it.
  always @(posedge clk) begin
    if (reset) begin
      rst_seen  = 1'b1;
      last_edge = -1;
      n_real    = 0;
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < HL; j++) hist[i][j] = 1'b1;
        mdeb[i]  = 1'b1;
        armed[i] = 1'b0;
        shist[i] = 0;
      end
      m_num = 0; m_cnt = 0; m_led = 1'b0;
      exp_q.delete();
    end else begin
      int k;
      k        = last_edge + 1;
      rst_seen = 1'b0;
      for (int i = 0; i < 2; i++)
        for (int j = HL - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[0][0] = bus.key_insert_n;
      hist[1][0] = bus.key_finish_n;
      shist[1]   = shist[0];
      shist[0]   = int'(bus.sw_num);
      n_real++;
      for (int i = 0; i < 2; i++) begin
        bit all_diff;
        if (n_real >= 3 && hist[i][2]) armed[i] = 1'b1;
        all_diff = 1'b1;
        for (int j = 2; j < HL; j++) if (hist[i][j] == mdeb[i]) all_diff = 1'b0;
        press[i] = 1'b0;
        if (all_diff) begin
          mdeb[i]  = ~mdeb[i];
          press[i] = !mdeb[i] && armed[i];
        end
      end
      if (press[0]) begin
        if (shist[1] <= 9) begin
          m_num = shist[1];
          if (m_cnt < 7) m_cnt++;
          m_led = 1'b0;
          push_evt(k + 1, 1'b1, 1'b0, 1'b0);
        end else begin
          m_led = 1'b1;
          push_evt(k + 1, 1'b0, 1'b1, 1'b0);
        end
      end
      if (press[1]) push_evt(press[0] ? k + 2 : k + 1, 1'b0, 1'b0, 1'b1);
      last_edge = k;
    end
  end

  // Monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_seen) begin
      vis_num = 0; vis_cnt = 0; vis_led = 1'b0;
      check("rst_pulses", {bus.insert, bus.err, bus.finish}, 0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < last_edge) begin
        mon_e = exp_q.pop_front();
        check("missing_pulse_at_edge", last_edge, mon_e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == last_edge) begin
        mon_e   = exp_q.pop_front();
        vis_num = mon_e.num;
        vis_cnt = mon_e.cnt;
        vis_led = mon_e.led;
        check("insert", bus.insert, mon_e.ins);
        check("err",    bus.err,    mon_e.err);
        check("finish", bus.finish, mon_e.fin);
      end else begin
        check("unexpected_pulse", {bus.insert, bus.err, bus.finish}, 0);
      end
      check("insert_finish_overlap", bus.insert & bus.finish, 0);
    end
    check("num",        bus.num,        vis_num);
    check("insert_cnt", bus.insert_cnt, vis_cnt);
    check("err_led",    bus.err_led,    vis_led);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int key, input int hold, input int rel);
    if (key == 0) bus.key_insert_n = 1'b0; else bus.key_finish_n = 1'b0;
    step(hold);
    if (key == 0) bus.key_insert_n = 1'b1; else bus.key_finish_n = 1'b1;
    step(rel);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int lat;
    bus.sw_num       = 4'd0;
    bus.key_insert_n = 1'b1;
    bus.key_finish_n = 1'b1;
    reset            = 1'b1;
    step(3);
    reset = 1'b0;
    step(5);

    // clean press
    bus.sw_num = 4'd5;
    step(3);
    d0  = last_edge;
    lat = -1;
    bus.key_insert_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.insert) begin
        lat = last_edge - d0;
        break;
      end
    end
    check("clean_latency", lat, 7);
    step(12);
    bus.key_insert_n = 1'b1;
    step(12);
    check("clean_num", bus.num, 5);
    check("clean_cnt", bus.insert_cnt, 1);

    // bounce on press and release
    for (int i = 0; i < 6; i++) begin
      bus.key_insert_n = ~bus.key_insert_n;
      step(2);
    end
    bus.key_insert_n = 1'b0;
    step(15);
    for (int i = 0; i < 6; i++) begin
      bus.key_insert_n = ~bus.key_insert_n;
      step(2);
    end
    bus.key_insert_n = 1'b1;
    step(15);
    check("bounce_cnt", bus.insert_cnt, 2);

    // invalid digit then a valid zero
    bus.sw_num = 4'd12;
    step(3);
    press_key(0, 10, 10);
    check("invalid_led", bus.err_led, 1);
    check("invalid_num_held", bus.num, 5);
    check("invalid_cnt_held", bus.insert_cnt, 2);
    bus.sw_num = 4'd0;
    step(3);
    press_key(0, 10, 10);
    check("zero_num", bus.num, 0);
    check("zero_led_clear", bus.err_led, 0);

    // simultaneous presses
    bus.sw_num = 4'd9;
    step(3);
    bus.key_insert_n = 1'b0;
    bus.key_finish_n = 1'b0;
    step(12);
    bus.key_insert_n = 1'b1;
    bus.key_finish_n = 1'b1;
    step(12);
    check("simul_num", bus.num, 9);

    // saturation
    for (int i = 0; i < 9; i++) begin
      bus.sw_num = 4'($urandom_range(0, 9));
      step(3);
      press_key(0, 8, 8);
    end
    check("sat_cnt", bus.insert_cnt, 7);

    // reset mid-debounce with the key still held
    bus.key_insert_n = 1'b0;
    step(4);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    check("post_rst_num", bus.num, 0);
    check("post_rst_cnt", bus.insert_cnt, 0);
    check("post_rst_led", bus.err_led, 0);
    step(20);
    check("held_no_pulse_cnt", bus.insert_cnt, 0);
    bus.key_insert_n = 1'b1;
    step(10);
    bus.sw_num = 4'd3;
    step(3);
    press_key(0, 10, 10);
    check("repress_cnt", bus.insert_cnt, 1);
    check("repress_num", bus.num, 3);

    // random bursts on both keys and the switches
    for (int i = 0; i < 120; i++) begin
      bus.sw_num       = 4'($urandom_range(0, 15));
      bus.key_insert_n = 1'($urandom_range(0, 1));
      bus.key_finish_n = 1'($urandom_range(0, 1));
      step($urandom_range(1, 9));
    end
    bus.key_insert_n = 1'b1;
    bus.key_finish_n = 1'b1;
    step(20);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
